fc_weight_sequencer: RTL and testbench
======================================

# fc_weight_sequencer

Controller that sequences the fully-connected weight ROM for one layer pass. On `start` it walks the ROM row address from 0 to INPUT_NODES-1, pairs each returned row of OUTPUT_NODES weights with the matching input activation, and streams the pairs to the downstream MAC/accumulator stage over a valid/ready handshake. It hides the ROM's one-cycle read latency, absorbs downstream backpressure without dropping rows, and sustains one row per cycle when unstalled.

## Interface
- `DATA_WIDTH`, 8, width of one weight and one activation
- `INPUT_NODES`, 24, number of ROM rows; one row per input activation
- `OUTPUT_NODES`, 128, weights per row
- `ADDR_WIDTH`, 8, ROM address width; INPUT_NODES ≤ 2^ADDR_WIDTH
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a pass; sampled only in IDLE
- `act_in` in DATA_WIDTH*INPUT_NODES: activation vector; element i at bits [(INPUT_NODES-1-i)*DATA_WIDTH +: DATA_WIDTH]; latched on accepted `start`
- `mem_address` out ADDR_WIDTH: ROM row address, registered
- `mem_weights` in DATA_WIDTH*OUTPUT_NODES: ROM data, valid one cycle after the address edge
- `out_valid` out 1: row beat available
- `out_ready` in 1: downstream accepts beat when `out_valid && out_ready`
- `out_weights` out DATA_WIDTH*OUTPUT_NODES: row i weights, ROM packing unchanged
- `out_act` out DATA_WIDTH: activation element i
- `out_index` out ADDR_WIDTH: row index i
- `out_first`, `out_last` out 1: beat is row 0 / row INPUT_NODES-1
- `busy` out 1: high from accepted `start` until `done`
- `done` out 1: one-cycle pulse after the last beat handshakes

## Operation
- States: IDLE, FETCH, DRAIN. Transitions:
  - IDLE→FETCH on `start`
  - FETCH→DRAIN after issuing address INPUT_NODES-1
  - DRAIN→IDLE when the last beat handshakes; `done`=1 for that next cycle
- Issue rule: `outstanding` = inflight flag (0/1) + buffered beats (0..2). A new address issues in FETCH iff `outstanding − (out_valid && out_ready) < 2`. Issue sets inflight; the next cycle `mem_weights` is captured into the buffer tagged with index and activation.
- Buffer: 2-entry FIFO (output register + skid). Output is in-order, never dropped, never duplicated.
- Non-issue cycles: the ROM still reads, but data is ignored (inflight=0). Addresses ≥ INPUT_NODES are never issued.
- `start` while busy is ignored. `act_in` changes after acceptance have no effect.
- `out_*` payload is held stable while `out_valid && !out_ready`.
- Reset values: `mem_address`=0; `out_valid`, `busy`, `done`, `out_first`, `out_last`=0; `out_weights`, `out_act`, `out_index`=0. State=IDLE; buffer and inflight cleared.
- `rst` mid-pass aborts immediately. In-flight and buffered rows are discarded and no `done` is raised.

## Timing
- `start` sampled at edge E0: `mem_address`=0 after E0; ROM data after E1; `out_valid` with row 0 after E2.
- Unstalled (`out_ready`=1): beat i is valid in the cycle after E(2+i). The last beat handshakes in that cycle; `done` is high in the cycle after E(2+INPUT_NODES). For 24 rows, `done` follows E26. `busy` drops with `done`.
- Throughput: 1 row/cycle. A stall of k cycles delays all later beats by exactly k. After a stall releases, the next beat follows with no bubble.
- Back-to-back: `start` is accepted in the IDLE cycle after `done` at the earliest.

## Structure
- Shared package `fc_seq_pkg`: state enum (IDLE/FETCH/DRAIN), FIFO depth constant 2, `$clog2`-derived index width helpers.
- Sub-module `row_skid_fifo`: 2-entry FIFO holding {weights, act, index}. It provides push, pop (= valid&&ready), count, and a head payload.
- Top level: FSM, address counter, inflight flag, `act_in` latch, first/last decode.

## Test plan
- Nominal pass: ROM row r = all bytes r+1, `act_in` element i = 8'h10+i, `out_ready`=1. Expect 24 beats, index 0..23, weights bytes = index+1, `out_act`=8'h10+index, `out_first` on 0, `out_last` on 23, `done` one cycle after E26.
- Backpressure: drop `out_ready` for 3 cycles at beat 5, then toggle it every other cycle. Expect all 24 beats in order, payload held stable while stalled, `mem_address` never more than 2 rows ahead of the last accepted index, `done` delayed by the total stall cycles.
- `out_ready`=0 from the start. Expect exactly 2 addresses issued (0, 1), then `mem_address` frozen and `out_valid`=1 with row 0 held indefinitely.
- `start` pulsed at beats 3 and 10 mid-pass. Expect it ignored, 24 beats total, one `done`.
- `rst` asserted for 1 cycle at beat 12, then a new `start`. Expect all outputs at reset values the cycle after reset, no `done` from the aborted pass, and the new pass starting from index 0 with the new `act_in`.
- Back-to-back passes: `start` in the first IDLE cycle after `done`. Expect the second pass timing identical to the first.

Source files
------------

// File: rtl/fc_seq_pkg.sv
// -----------------------------------------------------------------------------
// fc_seq_pkg
// Shared types and sizing constants for the fully-connected weight sequencer:
//   - seq_state_e   : sequencer FSM state encoding
//   - FIFO_DEPTH    : rows buffered between the ROM and the downstream stage
//   - FIFO_CNT_W    : width of a 0..FIFO_DEPTH occupancy count
//   - OUTSTANDING_W : width of inflight + buffered rows (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
package fc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_e;

   localparam int FIFO_DEPTH    = 2;
   localparam int FIFO_CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int OUTSTANDING_W = $clog2(FIFO_DEPTH + 2);

endpackage

// File: rtl/fc_weight_sequencer_if.sv
// -----------------------------------------------------------------------------
// fc_weight_sequencer_if
// Row-beat stream from the weight sequencer to the MAC/accumulator stage.
//   out_valid   : beat available (source)
//   out_ready   : sink accepts beat when out_valid && out_ready
//   out_weights : one ROM row, ROM packing unchanged
//   out_act     : activation paired with the row
//   out_index   : row index
//   out_first   : beat is row 0
//   out_last    : beat is the final row
// Modports: master = sequencer side, slave = downstream side.
// -----------------------------------------------------------------------------
interface fc_weight_sequencer_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int OUTPUT_NODES = 128,
   parameter int ADDR_WIDTH   = 8
) ();

   logic                                 out_valid;
   logic                                 out_ready;
   logic [DATA_WIDTH*OUTPUT_NODES-1:0]   out_weights;
   logic [DATA_WIDTH-1:0]                out_act;
   logic [ADDR_WIDTH-1:0]                out_index;
   logic                                 out_first;
   logic                                 out_last;

   modport master (
      output out_valid,
      input  out_ready,
      output out_weights,
      output out_act,
      output out_index,
      output out_first,
      output out_last
   );

   modport slave (
      input  out_valid,
      output out_ready,
      input  out_weights,
      input  out_act,
      input  out_index,
      input  out_first,
      input  out_last
   );

endinterface

// File: rtl/row_skid_fifo.sv
// -----------------------------------------------------------------------------
// row_skid_fifo
// Two-entry in-order buffer for {weights, act, index}: a head (output)
// register plus one skid register. The head payload only changes on a pop or
// when the buffer is empty, so it stays stable while the sink stalls.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push_i, push_*_i    : write one row (caller guarantees space)
//   pop_i               : head consumed (caller guarantees head_valid_o)
//   count_o             : occupancy 0..2
//   head_valid_o        : head holds a row
//   head_*_o            : head payload
// -----------------------------------------------------------------------------
module row_skid_fifo
   import fc_seq_pkg::*;
#(
   parameter int WEIGHTS_W = 1024,
   parameter int ACT_W     = 8,
   parameter int INDEX_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [WEIGHTS_W-1:0]  push_weights_i,
   input  logic [ACT_W-1:0]      push_act_i,
   input  logic [INDEX_W-1:0]    push_index_i,
   input  logic                  pop_i,
   output logic [FIFO_CNT_W-1:0] count_o,
   output logic                  head_valid_o,
   output logic [WEIGHTS_W-1:0]  head_weights_o,
   output logic [ACT_W-1:0]      head_act_o,
   output logic [INDEX_W-1:0]    head_index_o
);

   logic [FIFO_CNT_W-1:0] count_q,        count_d;
   logic [WEIGHTS_W-1:0]  head_weights_q, head_weights_d;
   logic [ACT_W-1:0]      head_act_q,     head_act_d;
   logic [INDEX_W-1:0]    head_index_q,   head_index_d;
   logic [WEIGHTS_W-1:0]  skid_weights_q, skid_weights_d;
   logic [ACT_W-1:0]      skid_act_q,     skid_act_d;
   logic [INDEX_W-1:0]    skid_index_q,   skid_index_d;

   always_comb begin
      count_d        = count_q;
      head_weights_d = head_weights_q;
      head_act_d     = head_act_q;
      head_index_d   = head_index_q;
      skid_weights_d = skid_weights_q;
      skid_act_d     = skid_act_q;
      skid_index_d   = skid_index_q;

      if (count_q == '0) begin
         if (push_i) begin
            head_weights_d = push_weights_i;
            head_act_d     = push_act_i;
            head_index_d   = push_index_i;
            count_d        = FIFO_CNT_W'(1);
         end
      end else if (count_q == FIFO_CNT_W'(1)) begin
         if (push_i && pop_i) begin
            head_weights_d = push_weights_i;
            head_act_d     = push_act_i;
            head_index_d   = push_index_i;
         end else if (push_i) begin
            skid_weights_d = push_weights_i;
            skid_act_d     = push_act_i;
            skid_index_d   = push_index_i;
            count_d        = FIFO_CNT_W'(2);
         end else if (pop_i) begin
            count_d        = '0;
         end
      end else begin
         // Full: a pop promotes the skid entry; a simultaneous push refills it.
         if (pop_i) begin
            head_weights_d = skid_weights_q;
            head_act_d     = skid_act_q;
            head_index_d   = skid_index_q;
            if (push_i) begin
               skid_weights_d = push_weights_i;
               skid_act_d     = push_act_i;
               skid_index_d   = push_index_i;
            end else begin
               count_d        = FIFO_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q        <= '0;
         head_weights_q <= '0;
         head_act_q     <= '0;
         head_index_q   <= '0;
         skid_weights_q <= '0;
         skid_act_q     <= '0;
         skid_index_q   <= '0;
      end else begin
         count_q        <= count_d;
         head_weights_q <= head_weights_d;
         head_act_q     <= head_act_d;
         head_index_q   <= head_index_d;
         skid_weights_q <= skid_weights_d;
         skid_act_q     <= skid_act_d;
         skid_index_q   <= skid_index_d;
      end
   end

   assign count_o        = count_q;
   assign head_valid_o   = (count_q != '0);
   assign head_weights_o = head_weights_q;
   assign head_act_o     = head_act_q;
   assign head_index_o   = head_index_q;

endmodule

// File: rtl/fc_weight_sequencer.sv
// -----------------------------------------------------------------------------
// fc_weight_sequencer
// Walks the fully-connected weight ROM rows 0..INPUT_NODES-1 for one layer
// pass, pairs each row with its latched input activation and streams the
// pairs downstream, hiding the ROM read latency and absorbing backpressure.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a pass (sampled in IDLE only)
//   act_in       : activation vector, element i at [(INPUT_NODES-1-i)*DW +: DW]
//   mem_address  : registered ROM row address
//   mem_weights  : ROM row data, valid the cycle after the ROM samples address
//   out_if       : row-beat stream (master side)
//   busy         : pass in progress
//   done         : one-cycle pulse after the last beat handshakes
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; address parked at 0 after start
// ST_FETCH | presenting row addresses while outstanding rows allow
// ST_DRAIN | all rows issued; waiting for the last beat to handshake
// -----------------------------------------------------------------------------
module fc_weight_sequencer
   import fc_seq_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int INPUT_NODES  = 24,
   parameter int OUTPUT_NODES = 128,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [DATA_WIDTH*INPUT_NODES-1:0]   act_in,
   output logic [ADDR_WIDTH-1:0]               mem_address,
   input  logic [DATA_WIDTH*OUTPUT_NODES-1:0]  mem_weights,
   fc_weight_sequencer_if.master               out_if,
   output logic                                busy,
   output logic                                done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(INPUT_NODES - 1);

   seq_state_e                         state_q, state_d;
   logic [ADDR_WIDTH-1:0]              mem_address_q, mem_address_d;
   logic                               inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0]              inflight_idx_q, inflight_idx_d;
   logic [DATA_WIDTH*INPUT_NODES-1:0]  act_q, act_d;
   logic                               done_q, done_d;

   logic                               start_acc;
   logic                               issue;
   logic                               last_addr;
   logic                               pop;
   logic [OUTSTANDING_W-1:0]           outstanding_after;
   logic [DATA_WIDTH-1:0]              act_sel;

   logic [FIFO_CNT_W-1:0]              fifo_count;
   logic                               head_valid;
   logic [DATA_WIDTH*OUTPUT_NODES-1:0] head_weights;
   logic [DATA_WIDTH-1:0]              head_act;
   logic [ADDR_WIDTH-1:0]              head_index;
   logic                               head_last;

   assign pop       = head_valid && out_if.out_ready;
   assign last_addr = (mem_address_q == LAST_ROW);
   assign head_last = (head_index == LAST_ROW);

   // Rows the sequencer is still responsible for once this cycle's pop is
   // taken out; a new address may issue only while this leaves buffer room.
   assign outstanding_after = OUTSTANDING_W'(inflight_q) + OUTSTANDING_W'(fifo_count)
                            - OUTSTANDING_W'(pop);

   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      issue     = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // The done cycle itself never accepts a new start.
            if (start && !done_q) begin
               start_acc = 1'b1;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            issue = (outstanding_after < OUTSTANDING_W'(FIFO_DEPTH));
            if (issue && last_addr) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && head_last) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      mem_address_d  = mem_address_q;
      inflight_d     = issue;
      inflight_idx_d = mem_address_q;
      act_d          = act_q;
      if (start_acc) begin
         mem_address_d = '0;
         act_d         = act_in;
      end else if (issue && !last_addr) begin
         mem_address_d = mem_address_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_address_q  <= '0;
         inflight_q     <= 1'b0;
         inflight_idx_q <= '0;
         act_q          <= '0;
         done_q         <= 1'b0;
      end else begin
         mem_address_q  <= mem_address_d;
         inflight_q     <= inflight_d;
         inflight_idx_q <= inflight_idx_d;
         act_q          <= act_d;
         done_q         <= done_d;
      end
   end

   // Activation for the row whose data is arriving this cycle.
   always_comb begin
      act_sel = '0;
      for (int i = 0; i < INPUT_NODES; i++) begin
         if (inflight_idx_q == ADDR_WIDTH'(i)) begin
            act_sel = act_q[(INPUT_NODES-1-i)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   row_skid_fifo #(
      .WEIGHTS_W (DATA_WIDTH*OUTPUT_NODES),
      .ACT_W     (DATA_WIDTH),
      .INDEX_W   (ADDR_WIDTH)
   ) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .push_i         (inflight_q),
      .push_weights_i (mem_weights),
      .push_act_i     (act_sel),
      .push_index_i   (inflight_idx_q),
      .pop_i          (pop),
      .count_o        (fifo_count),
      .head_valid_o   (head_valid),
      .head_weights_o (head_weights),
      .head_act_o     (head_act),
      .head_index_o   (head_index)
   );

   assign out_if.out_valid   = head_valid;
   assign out_if.out_weights = head_weights;
   assign out_if.out_act     = head_act;
   assign out_if.out_index   = head_index;
   assign out_if.out_first   = head_valid && (head_index == '0);
   assign out_if.out_last    = head_valid && head_last;

   assign mem_address = mem_address_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;

endmodule

// File: tb/tb_fc_weight_sequencer.sv
module tb_fc_weight_sequencer;

   localparam int DW = 8;
   localparam int IN = 24;
   localparam int ON = 128;
   localparam int AW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [DW*IN-1:0]  act_in;
   logic [AW-1:0]     mem_address;
   logic [DW*ON-1:0]  mem_weights = '0;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_pass   = 0;
   int c_now    = 0;

   fc_weight_sequencer_if #(.DATA_WIDTH(DW), .OUTPUT_NODES(ON), .ADDR_WIDTH(AW)) out_if ();

   fc_weight_sequencer #(
      .DATA_WIDTH   (DW),
      .INPUT_NODES  (IN),
      .OUTPUT_NODES (ON),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .act_in      (act_in),
      .mem_address (mem_address),
      .mem_weights (mem_weights),
      .out_if      (out_if),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW*ON-1:0] rep(input logic [7:0] b);
      logic [DW*ON-1:0] v;
      for (int k = 0; k < ON; k++) v[k*DW +: DW] = b;
      return v;
   endfunction

   function automatic logic [DW*IN-1:0] mk_act(input logic [7:0] base);
      logic [DW*IN-1:0] v;
      for (int k = 0; k < IN; k++) v[(IN-1-k)*DW +: DW] = base + 8'(k);
      return v;
   endfunction

   // ROM model: row r holds bytes r+1, one-cycle registered read.
   always @(posedge clk) mem_weights <= rep(mem_address + 8'd1);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c_now, obs, exp);
   endtask

   task automatic chk_w(input string tag, input logic [DW*ON-1:0] obs, input logic [DW*ON-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d observed(lo)=%0h expected(lo)=%0h", tag, c_now,
                  obs[63:0], exp[63:0]);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"},   64'(out_if.out_valid), 64'd0);
      chk({tag, "_busy"},    64'(busy), 64'd0);
      chk({tag, "_done"},    64'(done), 64'd0);
      chk({tag, "_firstlast"}, 64'({out_if.out_first, out_if.out_last}), 64'd0);
      chk({tag, "_addr"},    64'(mem_address), 64'd0);
      chk({tag, "_index"},   64'(out_if.out_index), 64'd0);
      chk({tag, "_act"},     64'(out_if.out_act), 64'd0);
      chk_w({tag, "_weights"}, out_if.out_weights, '0);
   endtask

   function automatic logic rdy_for(input int mode, input int c);
      case (mode)
         1:       return (c < 8) ? 1'b1 : (c <= 10) ? 1'b0 : (((c - 11) % 2) == 0);
         3:       return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Starts a pass at the current negedge (an IDLE cycle) and checks cycle by
   // cycle. mode 0: ready=1; 1: stall/toggle; 2: ready=1 + stray starts;
   // 3: ready=0 always. Cycle c is the cycle after edge E(c-1), E0 = start edge.
   task automatic run_pass(input int mode, input logic [7:0] base, input int exp_done,
                           input int abort_at);
      int nx;
      logic rdy;
      logic [AW-1:0] exp_addr;
      nx = 0;
      start = 1'b1;
      act_in = mk_act(base);
      for (int c = 1; c <= exp_done + 1; c++) begin
         @(negedge clk);
         c_now = c;
         start = (mode == 2) && (c == 6 || c == 13);
         if (c == 1) act_in = mk_act(8'hEE);
         chk("out_valid", 64'(out_if.out_valid), 64'(c >= 3 && nx < IN));
         chk("busy", 64'(busy), 64'(c < exp_done));
         chk("done", 64'(done), 64'(c == exp_done));
         if (mode == 0 || mode == 2) begin
            exp_addr = (c - 1 < IN - 1) ? AW'(c - 1) : AW'(IN - 1);
            chk("mem_address", 64'(mem_address), 64'(exp_addr));
         end else if (mode == 3) begin
            exp_addr = (c >= 3) ? AW'(2) : AW'(c - 1);
            chk("mem_address_frozen", 64'(mem_address), 64'(exp_addr));
         end else if (busy) begin
            chk("addr_lead", 64'(int'(mem_address) <= nx + 2), 64'd1);
         end
         if (out_if.out_valid) begin
            chk("out_index", 64'(out_if.out_index), 64'(nx));
            chk("out_act", 64'(out_if.out_act), 64'(8'(base + 8'(nx))));
            chk_w("out_weights", out_if.out_weights, rep(8'(nx + 1)));
            chk("first_last", 64'({out_if.out_first, out_if.out_last}),
                64'({nx == 0, nx == IN - 1}));
         end
         rdy = rdy_for(mode, c);
         out_if.out_ready = rdy;
         if (out_if.out_valid && rdy) nx++;
         if (c == abort_at) return;
      end
      chk("beat_count", 64'(nx), 64'(IN));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      act_in = '0;
      out_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;
      @(negedge clk);

      // Nominal pass, then a back-to-back pass started in the first IDLE
      // cycle after done: timing must be identical.
      run_pass(0, 8'h10, 27, 0);
      run_pass(0, 8'h20, 27, 0);

      // Backpressure: 3-cycle stall at beat 5, then ready toggles; 21 stall
      // cycles in total push done from cycle 27 to 48.
      run_pass(1, 8'h10, 48, 0);

      // Stray start pulses during the pass are ignored.
      run_pass(2, 8'h30, 27, 0);

      // Ready held low: two rows fetched, address stops at 2, row 0 held.
      run_pass(3, 8'h10, 1000, 12);
      rst = 1'b1;
      @(negedge clk);
      c_now = -1;
      check_reset_outputs("stall_rst");
      rst = 1'b0;

      // Abort at beat 12 with a one-cycle reset, then a fresh pass.
      run_pass(0, 8'h10, 27, 15);
      rst = 1'b1;
      @(negedge clk);
      c_now = -2;
      check_reset_outputs("abort_rst");
      rst = 1'b0;
      out_if.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no_done_after_abort", 64'(done), 64'd0);
         chk("idle_after_abort", 64'(busy), 64'd0);
      end
      run_pass(0, 8'h40, 27, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
